rr_arbiter_8: RTL and testbench

Eight-input round-robin arbiter. It grants one requester at a time and holds the grant until the consumer signals completion. The granted requester is output as a registered 3-bit index with a valid flag. It sits directly upstream of the 3-to-8 decoder, which turns `gnt_idx` into a one-hot enable vector for the selected unit.

---
 rtl/rr_arbiter_8.sv | 129 ++++++++++++
 tb/tb_rr_arbiter_8.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-input round-robin arbiter with held grant.
// Define RR_ARB_TIMEOUT_EN to bound each grant to TIMEOUT cycles.
module rr_arbiter_8 #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  ptr;
    logic [2:0]  ptr_nxt;
    logic [2:0]  idx_nxt;
    logic        vld_nxt;
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;
    logic [2:0]  sel;

    // rot[0] is the requester at ptr, so the lowest set bit wins
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[7:0];

    always_comb begin
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                off = 3'(i);
            end
        end
    end

    assign sel = ptr + off;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       to_nxt;
`else
    logic unused_timeout_param;

    assign unused_timeout_param = ^8'(TIMEOUT);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = gnt_idx;
        vld_nxt   = gnt_vld;
        ptr_nxt   = ptr;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_nxt   = cnt;
        to_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                vld_nxt = 1'b0;
                if (|req) begin
                    idx_nxt   = sel;
                    vld_nxt   = 1'b1;
                    state_nxt = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_nxt   = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (done) begin
                    vld_nxt   = 1'b0;
                    ptr_nxt   = gnt_idx + 3'd1;
                    state_nxt = IDLE;
`ifdef RR_ARB_TIMEOUT_EN
                end else if (cnt == CNT_LAST) begin
                    vld_nxt   = 1'b0;
                    to_nxt    = 1'b1;
                    ptr_nxt   = gnt_idx + 3'd1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = cnt + 8'd1;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            gnt_idx <= 3'd0;
            gnt_vld <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_idx <= idx_nxt;
            gnt_vld <= vld_nxt;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 8'd0;
            timeout <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            timeout <= to_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed bench with a behavioural arbiter model.
// Build with RR_ARB_TIMEOUT_EN to exercise the grant timer.
module tb_rr_arbiter_8;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int total = 0;
    int bad = 0;

    int m_vld = 0;
    int m_idx = 0;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_to = 0;

    rr_arbiter_8 #(.TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .gnt_idx(gnt_idx),
        .gnt_vld(gnt_vld),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: search from ptr upward mod 8; release moves ptr past winner
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld = 0;
            m_idx = 0;
            m_ptr = 0;
            m_cnt = 0;
            m_to  = 0;
        end else begin
            m_to = 0;
            if (m_vld == 0) begin
                bit found;
                found = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (!found && req[(m_ptr + k) % 8]) begin
                        found = 1'b1;
                        m_idx = (m_ptr + k) % 8;
                    end
                end
                if (found) begin
                    m_vld = 1;
                    m_cnt = 0;
                end
            end else if (done) begin
                m_vld = 0;
                m_ptr = (m_idx + 1) % 8;
            end else begin
                m_cnt = m_cnt + 1;
`ifdef RR_ARB_TIMEOUT_EN
                if (m_cnt == TMO) begin
                    m_vld = 0;
                    m_to  = 1;
                    m_ptr = (m_idx + 1) % 8;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        chk("model_vld", int'(gnt_vld), m_vld);
        chk("model_idx", int'(gnt_idx), m_idx);
        chk("model_timeout", int'(timeout), m_to);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Release the live grant and expect the next one after one idle cycle
    task automatic release_and_expect(input logic [7:0] nreq, input int exp_idx);
        req  = nreq;
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk("idle_gap_vld", int'(gnt_vld), 0);
        cyc();
        chk("next_vld", int'(gnt_vld), 1);
        chk("next_idx", int'(gnt_idx), exp_idx);
    endtask

    initial begin
        int hi;
        req = 8'hFF;
        rst = 1'b1;
        repeat (3) cyc();
        chk("reset_vld", int'(gnt_vld), 0);
        chk("reset_idx", int'(gnt_idx), 0);
        chk("reset_timeout", int'(timeout), 0);
        rst = 1'b0;
        cyc();
        chk("first_vld", int'(gnt_vld), 1);
        chk("first_idx", int'(gnt_idx), 0);

        for (int i = 1; i <= 8; i++) begin
            release_and_expect(8'hFF, i % 8);
        end

        release_and_expect(8'h40, 6);
        release_and_expect(8'b0010_0001, 0);
        release_and_expect(8'b0010_0001, 5);

        release_and_expect(8'h08, 3);
        req = 8'h02;
        repeat (5) begin
            cyc();
            chk("hold_idx", int'(gnt_idx), 3);
            chk("hold_vld", int'(gnt_vld), 1);
        end
        release_and_expect(8'h02, 1);

        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_vld", int'(gnt_vld), 0);
        chk("async_rst_idx", int'(gnt_idx), 0);
        cyc();
        req = 8'h80;
        rst = 1'b0;
        cyc();
        chk("post_rst_vld", int'(gnt_vld), 1);
        chk("post_rst_idx", int'(gnt_idx), 7);

        release_and_expect(8'h04, 2);
        req = 8'hFF;
`ifdef RR_ARB_TIMEOUT_EN
        hi = 0;
        for (int n = 0; n < 20; n++) begin
            if (gnt_vld) begin
                hi++;
                cyc();
            end
        end
        chk("timeout_len", hi, TMO);
        chk("timeout_pulse", int'(timeout), 1);
        chk("timeout_vld", int'(gnt_vld), 0);
        cyc();
        chk("timeout_clear", int'(timeout), 0);
        chk("after_to_vld", int'(gnt_vld), 1);
        chk("after_to_idx", int'(gnt_idx), 3);
`else
        hi = 0;
        for (int n = 0; n < 110; n++) begin
            cyc();
            if (gnt_vld && gnt_idx == 3'd2 && !timeout) begin
                hi++;
            end
        end
        chk("held_cycles", hi, 110);
        chk("held_timeout", int'(timeout), 0);
`endif
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
